// File: rtl/yl3_shift_chain.sv
// Serial driver for a daisy chain of NUM_REGS 74HC595s: shifts one word per transfer, then
// strobes RCLK. Optional /OE control is compiled in with `define YL3_OE_CTRL_EN.
module yl3_shift_chain #(
  parameter int unsigned NUM_REGS  = 2,
  parameter int unsigned SETUP_CYC = 7,
  parameter int unsigned PULSE_CYC = 6,
  parameter int unsigned CNT_W     = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [8*NUM_REGS-1:0]   DATA_IN,
  input  logic                    LSB_FIRST,
  input  logic                    EN_IN,
`ifdef YL3_OE_CTRL_EN
  input  logic                    BLANK,
  output logic                    OE_N,
`endif
  output logic                    RDY,
  output logic                    DONE,
  output logic                    RCLK,
  output logic                    SRCLK,
  output logic                    SER_OUT
);

  localparam int unsigned W     = 8 * NUM_REGS;
  localparam int unsigned BIT_W = $clog2(W);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(W - 1);

  typedef enum logic [2:0] {
    StIdle,
    StBitSetup,
    StBitHigh,
    StLatSetup,
    StLatHigh
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic [BIT_W-1:0] bcnt_q, bcnt_d;
  logic [W-1:0]     shreg_q, shreg_d;
  logic             lsb_q, lsb_d;
  logic             ser_q, ser_d;
  logic             srclk_q, srclk_d;
  logic             rclk_q, rclk_d;
  logic             rdy_q, rdy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    lsb_d   = lsb_q;
    ser_d   = ser_q;
    srclk_d = srclk_q;
    rclk_d  = rclk_q;
    rdy_d   = rdy_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        rdy_d = 1'b1;
        if (EN_IN) begin
          shreg_d = DATA_IN;
          lsb_d   = LSB_FIRST;
          rdy_d   = 1'b0;
          bcnt_d  = '0;
          tcnt_d  = '0;
          ser_d   = LSB_FIRST ? DATA_IN[0] : DATA_IN[W-1];
          state_d = StBitSetup;
        end
      end

      StBitSetup: begin
        if (tcnt_q == SETUP_LAST) begin
          tcnt_d  = '0;
          srclk_d = 1'b1;
          state_d = StBitHigh;
        end else begin
          tcnt_d = tcnt_q + CNT_W'(1);
        end
      end

      StBitHigh: begin
        if (tcnt_q == PULSE_LAST) begin
          tcnt_d  = '0;
          srclk_d = 1'b0;
          if (bcnt_q < BIT_LAST) begin
            // Next bit is presented on the same edge SRCLK falls.
            bcnt_d  = bcnt_q + BIT_W'(1);
            shreg_d = lsb_q ? (shreg_q >> 1) : (shreg_q << 1);
            ser_d   = lsb_q ? shreg_q[1] : shreg_q[W-2];
            state_d = StBitSetup;
          end else begin
            ser_d   = 1'b0;
            state_d = StLatSetup;
          end
        end else begin
          tcnt_d = tcnt_q + CNT_W'(1);
        end
      end

      StLatSetup: begin
        if (tcnt_q == SETUP_LAST) begin
          tcnt_d  = '0;
          rclk_d  = 1'b1;
          state_d = StLatHigh;
        end else begin
          tcnt_d = tcnt_q + CNT_W'(1);
        end
      end

      StLatHigh: begin
        if (tcnt_q == PULSE_LAST) begin
          tcnt_d  = '0;
          rclk_d  = 1'b0;
          done_d  = 1'b1;
          rdy_d   = 1'b1;
          state_d = StIdle;
        end else begin
          tcnt_d = tcnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = StIdle;
        tcnt_d  = '0;
        srclk_d = 1'b0;
        rclk_d  = 1'b0;
        ser_d   = 1'b0;
        rdy_d   = 1'b1;
      end
    endcase
  end

  // A reset mid-transfer drops the partial shift without an RCLK strobe, so the 595
  // outputs keep the last completed word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
      lsb_q   <= 1'b0;
      ser_q   <= 1'b0;
      srclk_q <= 1'b0;
      rclk_q  <= 1'b0;
      rdy_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      lsb_q   <= lsb_d;
      ser_q   <= ser_d;
      srclk_q <= srclk_d;
      rclk_q  <= rclk_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
    end
  end

  assign RDY     = rdy_q;
  assign DONE    = done_q;
  assign RCLK    = rclk_q;
  assign SRCLK   = srclk_q;
  assign SER_OUT = ser_q;

`ifdef YL3_OE_CTRL_EN
  // Outputs stay blanked until a full word has been latched after reset.
  logic armed_q;
  logic oe_n_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      armed_q <= 1'b0;
      oe_n_q  <= 1'b1;
    end else begin
      if (done_d) begin
        armed_q <= 1'b1;
      end
      oe_n_q <= (armed_q || done_d) ? BLANK : 1'b1;
    end
  end

  assign OE_N = oe_n_q;
`endif

endmodule

// File: tb/tb_yl3_shift_chain.sv
// Directed bench for yl3_shift_chain: default instance (W=16) plus a fast 24-bit instance,
// each observed through a 595 chain model.
module tb_yl3_shift_chain;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] data_a;
  logic [23:0] data_b;
  logic        lsb_a, lsb_b, en_a, en_b;
  logic        rdy_a, done_a, rclk_a, srclk_a, ser_a;
  logic        rdy_b, done_b, rclk_b, srclk_b, ser_b;
`ifdef YL3_OE_CTRL_EN
  logic        blank;
  logic        oe_n_a, oe_n_b;
`endif

  always #5 CLK = ~CLK;

  yl3_shift_chain dut_a (
    .CLK       (CLK),
    .RST       (RST),
    .DATA_IN   (data_a),
    .LSB_FIRST (lsb_a),
    .EN_IN     (en_a),
`ifdef YL3_OE_CTRL_EN
    .BLANK     (blank),
    .OE_N      (oe_n_a),
`endif
    .RDY       (rdy_a),
    .DONE      (done_a),
    .RCLK      (rclk_a),
    .SRCLK     (srclk_a),
    .SER_OUT   (ser_a)
  );

  yl3_shift_chain #(
    .NUM_REGS  (3),
    .SETUP_CYC (1),
    .PULSE_CYC (1),
    .CNT_W     (1)
  ) dut_b (
    .CLK       (CLK),
    .RST       (RST),
    .DATA_IN   (data_b),
    .LSB_FIRST (lsb_b),
    .EN_IN     (en_b),
`ifdef YL3_OE_CTRL_EN
    .BLANK     (blank),
    .OE_N      (oe_n_b),
`endif
    .RDY       (rdy_b),
    .DONE      (done_b),
    .RCLK      (rclk_b),
    .SRCLK     (srclk_b),
    .SER_OUT   (ser_b)
  );

  logic srclk_v [2];
  logic rclk_v  [2];
  logic ser_v   [2];
  logic done_v  [2];
  assign srclk_v[0] = srclk_a;
  assign srclk_v[1] = srclk_b;
  assign rclk_v[0]  = rclk_a;
  assign rclk_v[1]  = rclk_b;
  assign ser_v[0]   = ser_a;
  assign ser_v[1]   = ser_b;
  assign done_v[0]  = done_a;
  assign done_v[1]  = done_b;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // 595 chain model and pin statistics, one set per instance
  int          rises      [2];
  int          rclk_rises [2];
  int          done_cnt   [2];
  int          ser_viol   [2];
  int          hmin [2], hmax [2], lmin [2], lmax [2];
  int          run        [2];
  logic        seen_fall  [2];
  logic [31:0] chain      [2];
  logic [31:0] lat        [2][8];
  int          lat_rises  [2][8];
  int          done_t     [2][8];
  logic        p_srclk [2] = '{1'b0, 1'b0};
  logic        p_rclk  [2] = '{1'b0, 1'b0};
  logic        p_ser   [2] = '{1'b0, 1'b0};

  always @(posedge CLK) cyc++;

  always @(posedge CLK) begin
    #2;
    for (int d = 0; d < 2; d++) begin
      if (srclk_v[d] !== p_srclk[d]) begin
        if (p_srclk[d]) begin
          if (run[d] < hmin[d]) hmin[d] = run[d];
          if (run[d] > hmax[d]) hmax[d] = run[d];
          seen_fall[d] = 1'b1;
        end else begin
          if (seen_fall[d]) begin
            if (run[d] < lmin[d]) lmin[d] = run[d];
            if (run[d] > lmax[d]) lmax[d] = run[d];
          end
          rises[d]++;
          chain[d] = {chain[d][30:0], ser_v[d]};
        end
        run[d] = 1;
      end else begin
        run[d]++;
      end
      if (srclk_v[d] && p_srclk[d] && (ser_v[d] !== p_ser[d])) ser_viol[d]++;
      if (rclk_v[d] && !p_rclk[d]) begin
        if (rclk_rises[d] < 8) begin
          lat[d][rclk_rises[d]]       = chain[d];
          lat_rises[d][rclk_rises[d]] = rises[d];
        end
        rclk_rises[d]++;
      end
      if (done_v[d] === 1'b1) begin
        if (done_cnt[d] < 8) done_t[d][done_cnt[d]] = cyc;
        done_cnt[d]++;
        seen_fall[d] = 1'b0;
      end
      p_srclk[d] = srclk_v[d];
      p_rclk[d]  = rclk_v[d];
      p_ser[d]   = ser_v[d];
    end
  end

  task automatic reset_stats(input int d);
    rises[d]      = 0;
    rclk_rises[d] = 0;
    done_cnt[d]   = 0;
    ser_viol[d]   = 0;
    hmin[d]       = 999;
    hmax[d]       = 0;
    lmin[d]       = 999;
    lmax[d]       = 0;
    run[d]        = 0;
    seen_fall[d]  = 1'b0;
    chain[d]      = '0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic [15:0] w, input logic lsb, output int k);
    data_a = w;
    lsb_a  = lsb;
    en_a   = 1'b1;
    @(negedge CLK);
    k    = cyc;
    en_a = 1'b0;
  endtask

  task automatic wait_done(input int d, input int target, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (done_cnt[d] >= target) break;
      @(negedge CLK);
    end
  endtask

  int k;

  initial begin
    RST    = 1'b1;
    en_a   = 1'b0;
    en_b   = 1'b0;
    lsb_a  = 1'b0;
    lsb_b  = 1'b0;
    data_a = '0;
    data_b = '0;
`ifdef YL3_OE_CTRL_EN
    blank  = 1'b0;
`endif
    reset_stats(0);
    reset_stats(1);

    // 1: reset and idle
    repeat (3) @(negedge CLK);
    check("rst_pins_a", {rdy_a, done_a, rclk_a, srclk_a, ser_a}, 5'b10000);
    check("rst_pins_b", {rdy_b, done_b, rclk_b, srclk_b, ser_b}, 5'b10000);
    RST = 1'b0;
    reset_stats(0);
    reset_stats(1);
    repeat (20) @(negedge CLK);
    check("idle_pins_a", {rdy_a, done_a, rclk_a, srclk_a, ser_a}, 5'b10000);
    check("idle_rises_a", rises[0], 0);
`ifdef YL3_OE_CTRL_EN
    check("oe_before_done", oe_n_a, 1'b1);
`endif

    // 2: 16'hA50F MSB first, default timing
    send_a(16'hA50F, 1'b0, k);
    check("accept_rdy_low", rdy_a, 1'b0);
    wait_done(0, 1, 400);
    check("t2_latency", done_t[0][0] - k, 221);
    check("t2_done_rdy", {done_a, rdy_a}, 2'b11);
    check("t2_rises", rises[0], 16);
    check("t2_word", lat[0][0][15:0], 16'hA50F);
    check("t2_rclk_pulses", rclk_rises[0], 1);
    check("t2_high_min", hmin[0], 6);
    check("t2_high_max", hmax[0], 6);
    check("t2_low_min", lmin[0], 7);
    check("t2_low_max", lmax[0], 7);
    check("t2_ser_stable", ser_viol[0], 0);
`ifdef YL3_OE_CTRL_EN
    check("oe_after_done", oe_n_a, 1'b0);
`endif
    @(negedge CLK);
    check("t2_done_one_cycle", done_a, 1'b0);
`ifdef YL3_OE_CTRL_EN
    blank = 1'b1;
    @(negedge CLK);
    check("oe_blank_hi", oe_n_a, 1'b1);
    blank = 1'b0;
    @(negedge CLK);
    check("oe_blank_lo", oe_n_a, 1'b0);
`endif

    // 3: 16'h0001 LSB first, EN_IN pulses with 16'hFFFF while busy are ignored
    reset_stats(0);
    send_a(16'h0001, 1'b1, k);
    for (int i = 0; i < 90; i++) begin
      data_a = 16'hFFFF;
      lsb_a  = 1'b0;
      en_a   = (i % 3 == 0);
      @(negedge CLK);
    end
    en_a = 1'b0;
    check("t3_busy_rdy", rdy_a, 1'b0);
    wait_done(0, 1, 400);
    check("t3_latency", done_t[0][0] - k, 221);
    check("t3_rises", rises[0], 16);
    check("t3_word", lat[0][0][15:0], 16'h8000);
    repeat (5) @(negedge CLK);
    check("t3_no_extra", rclk_rises[0], 1);

    // 4: 24-bit fast instance, EN_IN held high, back-to-back words
    reset_stats(1);
    data_b = 24'h123456;
    lsb_b  = 1'b0;
    en_b   = 1'b1;
    @(negedge CLK);
    k = cyc;
    check("t4_accept", rdy_b, 1'b0);
    data_b = 24'hABCDEF;
    wait_done(1, 2, 300);
    en_b = 1'b0;
    check("t4_done1", done_t[1][0] - k, 50);
    check("t4_done2", done_t[1][1] - k, 101);
    check("t4_word1", lat[1][0][23:0], 24'h123456);
    check("t4_word2", lat[1][1][23:0], 24'hABCDEF);
    check("t4_rises1", lat_rises[1][0], 24);
    check("t4_rises2", lat_rises[1][1], 48);
    repeat (10) @(negedge CLK);
    check("t4_no_third", done_cnt[1], 2);

    // 5: reset after 5th SRCLK rise, then a clean word
    reset_stats(0);
    send_a(16'hFFFF, 1'b0, k);
    for (int i = 0; i < 200; i++) begin
      if (rises[0] >= 5) break;
      @(negedge CLK);
    end
    RST = 1'b1;
    @(negedge CLK);
    check("t5_rst_pins", {rdy_a, done_a, rclk_a, srclk_a, ser_a}, 5'b10000);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    check("t5_no_rclk", rclk_rises[0], 0);
    check("t5_partial_rises", rises[0], 5);
    reset_stats(0);
    send_a(16'h3C5A, 1'b0, k);
    wait_done(0, 1, 400);
    check("t5_latency", done_t[0][0] - k, 221);
    check("t5_rises", rises[0], 16);
    check("t5_word", lat[0][0][15:0], 16'h3C5A);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
